// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit controller.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    localparam logic [2:0] MEM_WORD = 3'b010;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/half lane extraction with sign/zero extension for loads, and
// read-modify-write word merging for sub-word stores.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  type_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    always_comb begin
        byte_c  = word_i[{off_i, 3'b000} +: 8];
        half_c  = off_i[1] ? word_i[31:16] : word_i[15:0];
        load_o  = word_i;
        merge_o = wdata_i;

        case (type_i)
            F3_LB:   load_o = {{24{byte_c[7]}}, byte_c};
            F3_LBU:  load_o = {24'd0, byte_c};
            F3_LH:   load_o = {{16{half_c[15]}}, half_c};
            F3_LHU:  load_o = {16'd0, half_c};
            default: load_o = word_i;
        endcase

        // Store types: only b/h reach here as sub-word, anything else is a full word.
        case (type_i)
            F3_LB: begin
                merge_o = word_i;
                merge_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            F3_LH: begin
                merge_o = word_i;
                merge_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            end
            default: merge_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: accepts one byte-addressed RV32I access at a time and
// turns it into full-word memory reads/writes with a one-cycle response strobe.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [1:0]  rsp_err,
    output logic [31:0] rsp_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [2:0]  mem_type,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    state_e      state_q, state_d;
    logic        write_q, write_d;
    logic [2:0]  type_q,  type_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] word_q,  word_d;
    logic [1:0]  err_q,   err_d;

    logic [1:0]  fault_c;
    logic [31:0] load_c;
    logic [31:0] merge_c;

    // word_q holds store data until READ replaces it with the merged or loaded word.
    lsu_lane_align u_align (
        .word_i  (mem_rdata),
        .off_i   (addr_q[1:0]),
        .type_i  (type_q),
        .wdata_i (word_q),
        .load_o  (load_c),
        .merge_o (merge_c)
    );

    // Fault classification in priority order: illegal, misaligned, out of range.
    always_comb begin
        fault_c = ERR_OK;
        if (req_write ? (req_type > F3_LW)
                      : ((req_type == 3'b011) || (req_type[2:1] == 2'b11))) begin
            fault_c = ERR_ILLEGAL;
        end else if (((req_type[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_type == F3_LW) && (req_addr[1:0] != 2'b00))) begin
            fault_c = ERR_MISALIGN;
        end else if ((32'(req_addr[31:2]) >> ADDR_WIDTH) != 32'd0) begin
            fault_c = ERR_RANGE;
        end
    end

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        type_d  = type_q;
        addr_d  = addr_q;
        word_d  = word_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    type_d  = req_type;
                    addr_d  = req_addr;
                    word_d  = req_wdata;
                    err_d   = fault_c;
                    if (fault_c != ERR_OK) begin
                        state_d = ST_RESP;
                    end else if (req_write && (req_type == F3_LW)) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                word_d  = write_q ? merge_c : load_c;
                state_d = write_q ? ST_WRITE : ST_RESP;
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            write_q <= 1'b0;
            type_q  <= 3'd0;
            addr_q  <= 32'd0;
            word_q  <= 32'd0;
            err_q   <= ERR_OK;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            type_q  <= type_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            err_q   <= err_d;
        end
    end

    // Outputs decode only state and registered request fields.
    assign req_ready = (state_q == ST_IDLE);
    assign mem_re    = (state_q == ST_READ);
    assign mem_we    = (state_q == ST_WRITE);
    assign mem_type  = MEM_WORD;
    assign mem_addr  = (mem_re || mem_we) ? {2'b00, addr_q[31:2]} : 32'd0;
    assign mem_wdata = mem_we ? word_q : 32'd0;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_err   = rsp_valid ? err_q : ERR_OK;
    assign rsp_rdata = (rsp_valid && !write_q && (err_q == ERR_OK)) ? word_q : 32'd0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed scenarios plus randomized requests
// compared against a byte-level reference model of memory and fault rules.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_type;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [1:0]  rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [2:0]  mem_type;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem     [512];
    logic [31:0] ref_mem [512];
    logic        load_mem;

    int checks = 0;
    int errors = 0;

    lsu_ctrl #(.ADDR_WIDTH(9)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_type  (req_type),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_type  (mem_type),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[8:0]];

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 512; i++) mem[i] <= ref_mem[i];
        end else if (mem_we) begin
            mem[mem_addr[8:0]] <= mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] model_err(input bit w, input logic [2:0] t, input logic [31:0] a);
        int unsigned sz;
        sz = 1 << t[1:0];
        if (w ? !(t inside {3'd0, 3'd1, 3'd2}) : (t inside {3'd3, 3'd6, 3'd7})) return 2'b11;
        if ((a % sz) != 0) return 2'b01;
        if ((a >> 2) >= 32'd512) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [2:0] t,
                                               input logic [31:0] a);
        int unsigned sz;
        longint v;
        longint span;
        sz   = 1 << t[1:0];
        span = longint'(1) << (8 * sz);
        v    = (longint'(word) >> (8 * (a % 4))) & (span - 1);
        if (!t[2] && sz < 4 && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] word, input logic [2:0] t,
                                                input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        int unsigned sz;
        int unsigned off;
        r   = word;
        sz  = 1 << t[1:0];
        off = a % 4;
        for (int i = 0; i < 4; i++) begin
            if (i < int'(sz)) r[8 * (int'(off) + i) +: 8] = d[8 * i +: 8];
        end
        return r;
    endfunction

    task automatic do_req(input bit w, input logic [2:0] t, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] got_rdata,
                          output logic [1:0] got_err, output int got_lat);
        int          idx;
        logic [1:0]  e;
        int          exp_lat;
        logic [31:0] exp_rd;
        logic [31:0] exp_wd;
        int          re_cnt;
        int          we_cnt;
        int          n;
        idx     = int'((a >> 2) & 32'd511);
        e       = model_err(w, t, a);
        exp_lat = (e != 2'b00) ? 1 : ((w && t != 3'd2) ? 3 : 2);
        exp_rd  = (!w && e == 2'b00) ? model_load(ref_mem[idx], t, a) : 32'd0;
        exp_wd  = model_store(ref_mem[idx], t, a, d);

        n = 0;
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(req_ready), 32'd1);

        req_valid = 1'b1;
        req_write = w;
        req_type  = t;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_type  = 3'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;

        got_lat   = 0;
        got_rdata = 32'd0;
        got_err   = 2'b00;
        re_cnt    = 0;
        we_cnt    = 0;
        for (int c = 1; c <= 6 && got_lat == 0; c++) begin
            @(negedge clk);
            chk("re_we_excl", 32'(mem_re & mem_we), 32'd0);
            chk("mem_type", 32'(mem_type), 32'd2);
            if (mem_re) begin
                re_cnt++;
                chk("rd_addr", mem_addr, 32'(idx));
            end
            if (mem_we) begin
                we_cnt++;
                chk("wr_addr", mem_addr, 32'(idx));
                chk("wr_data", mem_wdata, exp_wd);
            end
            if (rsp_valid) begin
                got_lat   = c;
                got_rdata = rsp_rdata;
                got_err   = rsp_err;
                chk("resp_addr0", mem_addr, 32'd0);
                chk("resp_wdata0", mem_wdata, 32'd0);
            end
        end
        chk("latency", 32'(got_lat), 32'(exp_lat));
        chk("rsp_err", 32'(got_err), 32'(e));
        chk("rsp_rdata", got_rdata, exp_rd);
        chk("re_count", 32'(re_cnt), (e == 2'b00 && !(w && t == 3'd2)) ? 32'd1 : 32'd0);
        chk("we_count", 32'(we_cnt), (e == 2'b00 && w) ? 32'd1 : 32'd0);
        if (e == 2'b00 && w) ref_mem[idx] = exp_wd;

        @(negedge clk);
        chk("ready_after", 32'(req_ready), 32'd1);
        chk("pulse_once", 32'(rsp_valid), 32'd0);
        chk("mem_word", mem[idx], ref_mem[idx]);
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  er;
        int          lat;
        int          pulses;
        int          pc [2];
        logic [31:0] pd [2];

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_type  = 3'd0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        load_mem  = 1'b1;
        for (int i = 0; i < 512; i++) ref_mem[i] = $urandom;
        ref_mem[5] = 32'h8899AABB;
        @(posedge clk);
        #1;
        load_mem = 1'b0;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_mem_re", 32'(mem_re), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_type", 32'(mem_type), 32'd2);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_req(1'b0, 3'b000, 32'h15, 32'd0, rd, er, lat);
        chk("plan_lb", rd, 32'hFFFFFFAA);
        chk("plan_lb_lat", 32'(lat), 32'd2);
        do_req(1'b0, 3'b100, 32'h15, 32'd0, rd, er, lat);
        chk("plan_lbu", rd, 32'h000000AA);
        do_req(1'b0, 3'b101, 32'h16, 32'd0, rd, er, lat);
        chk("plan_lhu", rd, 32'h00008899);
        do_req(1'b1, 3'b000, 32'h17, 32'h123456CC, rd, er, lat);
        chk("plan_sb_lat", 32'(lat), 32'd3);
        chk("plan_sb_word", mem[5], 32'hCC99AABB);
        do_req(1'b1, 3'b010, 32'h40, 32'hDEADBEEF, rd, er, lat);
        chk("plan_sw_lat", 32'(lat), 32'd2);
        chk("plan_sw_word", mem[16], 32'hDEADBEEF);
        do_req(1'b0, 3'b010, 32'h42, 32'd0, rd, er, lat);
        chk("plan_misalign", 32'(er), 32'd1);
        chk("plan_fault_lat", 32'(lat), 32'd1);
        do_req(1'b1, 3'b100, 32'h20, 32'h55, rd, er, lat);
        chk("plan_illegal", 32'(er), 32'd3);
        do_req(1'b0, 3'b010, 32'h800, 32'd0, rd, er, lat);
        chk("plan_range", 32'(er), 32'd2);

        // Back-to-back: valid held high across two loads.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_type  = 3'b010;
        req_addr  = 32'h20;
        @(posedge clk);
        #1;
        req_type = 3'b100;
        req_addr = 32'h21;
        pulses   = 0;
        pc[0] = 0; pc[1] = 0; pd[0] = 0; pd[1] = 0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) chk("b2b_busy", 32'(req_ready), 32'd0);
            if (rsp_valid) begin
                if (pulses < 2) begin
                    pc[pulses] = c;
                    pd[pulses] = rsp_rdata;
                end
                pulses++;
            end
            if (c == 4) req_valid = 1'b0;
        end
        chk("b2b_pulses", 32'(pulses), 32'd2);
        chk("b2b_cyc1", 32'(pc[0]), 32'd2);
        chk("b2b_cyc2", 32'(pc[1]), 32'd5);
        chk("b2b_data1", pd[0], ref_mem[8]);
        chk("b2b_data2", pd[1], {24'd0, ref_mem[8][15:8]});

        // Reset while an sh is in READ.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_type  = 3'b001;
        req_addr  = 32'h32;
        req_wdata = 32'h0000BEEF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_read", 32'(mem_re), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_re", 32'(mem_re), 32'd0);
        chk("rst_mid_we", 32'(mem_we), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_hold_we", 32'(mem_we), 32'd0);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_post_we", 32'(mem_we), 32'd0);
        end
        chk("rst_post_ready", 32'(req_ready), 32'd1);
        chk("rst_post_word", mem[12], ref_mem[12]);

        for (int k = 0; k < 400; k++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 2047));
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, rd, er, lat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store unit controller sitting between the microprogrammed control unit and the word-organised data memory. Accepts one byte-addressed RV32I load or store request at a time. Translates it into full-word memory accesses: byte-lane extraction and sign/zero extension for loads, read-modify-write for sub-word stores. Reports completion or a fault on a one-cycle response strobe.

## Interface
- ADDR_WIDTH, 9, word-index width of the attached data memory (2^ADDR_WIDTH words)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present (sampled only when req_ready=1)
- req_ready  out  1  high in IDLE only
- req_write  in  1  1=store, 0=load
- req_type  in  3  funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low bits used for b/h)
- rsp_valid  out  1  one-cycle completion pulse
- rsp_err  out  2  00 ok, 01 misaligned, 10 out of range, 11 illegal type
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- mem_addr  out  32  word index = req_addr[31:2]
- mem_re  out  1  memory read enable
- mem_we  out  1  memory write enable
- mem_type  out  3  constant 3'b010 (always full-word access)
- mem_wdata  out  32  merged full word
- mem_rdata  in  32  combinational read data for mem_addr

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE: req_ready=1. On req_valid, register the request, then check faults in priority order:
  - illegal type: store with type not in {000,001,010}; load with 011/110/111
  - misaligned: h/hu with addr[0]=1; w with addr[1:0]≠0
  - out of range: addr[31:2] ≥ 2^ADDR_WIDTH
- Any fault -> RESP with the fault code. No memory enable is asserted.
- Otherwise:
  - load or sub-word store -> READ
  - word store -> WRITE
- READ: mem_re=1 and mem_addr driven. Capture mem_rdata at the clock edge.
  - Load -> RESP. rsp_rdata = lane at offset addr[1:0]:
    - b: word[8*off+:8] sign-extended; bu: zero-extended
    - h: word[16*addr[1]+:16] sign-extended; hu: zero-extended
    - w: whole word
  - Sub-word store -> WRITE with merged word: captured word with the addressed byte or half replaced by req_wdata[7:0] / [15:0].
- WRITE: mem_we=1 for exactly one cycle with merged (or full req_wdata) word -> RESP.
- RESP: rsp_valid=1, rsp_err/rsp_rdata valid -> IDLE.
- mem_re and mem_we are never high together. mem_addr and mem_wdata are 0 in IDLE and RESP.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_err=00, rsp_rdata=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_type=010. State=IDLE.
- All outputs are registered or decoded from state and registered request only. There is no combinational path from req_* to mem_*.
- Latency counts from the acceptance edge (cycle 0) to rsp_valid high:
  - fault: cycle 1
  - load: cycle 2
  - word store: cycle 2
  - sub-word store: cycle 3
- Throughput: next request accepted in the cycle after RESP (req_ready high again).
- req_valid while req_ready=0 is ignored. The requester must hold the request until it is accepted.
- There is no response backpressure. rsp_valid is a single-cycle pulse.
- Reset mid-operation aborts immediately:
  - mem_we/mem_re drop asynchronously.
  - A store in READ never writes.
  - A store already in WRITE may or may not complete the write at that edge.

## Structure
- lsu_pkg holds:
  - state enum (IDLE, READ, WRITE, RESP)
  - funct3 constants (LB, LH, LW, LBU, LHU)
  - rsp_err encoding constants
  - MEM_WORD = 3'b010
- Sub-module lsu_lane_align (combinational) provides:
  - extract: word, offset, type -> extended load data
  - merge: old word, offset, type, wdata -> new word
- lsu_ctrl keeps the FSM, request registers and fault checks.

## Test plan
- Memory word 5 = 0x8899AABB:
  - lb at 0x15 -> rsp_rdata 0xFFFFFFAA, err 00, rsp_valid at cycle 2
  - lbu at 0x15 -> 0x000000AA
  - lhu at 0x16 -> 0x00008899
- sb 0x123456CC to 0x17 with word 5 = 0x8899AABB:
  - READ, then WRITE with mem_wdata 0xCC99AABB
  - rsp_valid at cycle 3, err 00
- sw 0xDEADBEEF to 0x40 -> single WRITE cycle, mem_addr 0x10, mem_wdata 0xDEADBEEF, no mem_re, rsp at cycle 2.
- Faults -> rsp at cycle 1, mem_re=mem_we=0 throughout:
  - lw at 0x42 -> err 01
  - store type 100 -> err 11
  - lw at 0x800 (ADDR_WIDTH=9) -> err 10
- Back-to-back: req_valid held high with two loads -> second accepted only after first RESP; pulses at cycles 2 and 5.
- rst_n low during READ of an sh -> mem_we never asserted; after release: req_ready=1, memory word unchanged.
